// File: rtl/gmii_tx_scheduler_pkg.sv
// Shared types and constants for the GMII transmit scheduler.
// One-hot FSM encoding, framing bytes and counter widths.
package gmii_tx_sched_pkg;

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_PREAMBLE = 6'b000010,
    ST_SFD      = 6'b000100,
    ST_DATA     = 6'b001000,
    ST_PAD      = 6'b010000,
    ST_IPG      = 6'b100000
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int PRE_W  = 4;
  localparam int BYTE_W = 11;
  localparam int IPG_W  = 8;

endpackage

// File: rtl/gmii_tx_scheduler_if.sv
// Byte-stream source handshake into the GMII transmit scheduler.
// master = frame source, slave = scheduler.
interface gmii_tx_scheduler_if;

  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       err;
  logic       ready;

  modport master (
    output valid, data, last, err,
    input  ready
  );

  modport slave (
    input  valid, data, last, err,
    output ready
  );

endinterface

// File: rtl/gmii_tx_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; pointer moves only on grant issue.
// After reset src0 wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last1;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last1 ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last1 <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last1 <= gnt[1];
    end
  end

endmodule

// File: rtl/gmii_tx_scheduler.sv
// GMII transmit scheduler: two sources, round-robin per frame, preamble/SFD, IPG.
// Optional minimum-length padding when GMII_TX_MIN_PAD_EN is defined.
module gmii_tx_scheduler
  import gmii_tx_sched_pkg::*;
#(
  parameter int unsigned IPG_BYTES    = 12,
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = 60
) (
  input  logic               GTX_CLK,
  input  logic               mr_main_reset,
  gmii_tx_scheduler_if.slave src0,
  gmii_tx_scheduler_if.slave src1,
  input  logic               transmitting,
  output logic [7:0]         TXD,
  output logic               TX_EN,
  output logic               TX_ER,
  output logic [1:0]         grant,
  output logic               busy
);

  localparam logic [PRE_W-1:0]  PreLast = PRE_W'(PREAMBLE_LEN - 1);
  localparam logic [IPG_W-1:0]  IpgLoad = IPG_W'(IPG_BYTES);
  localparam logic [BYTE_W-1:0] ByteMax = '1;
`ifdef GMII_TX_MIN_PAD_EN
  localparam logic [BYTE_W-1:0] MinLen  = BYTE_W'(MIN_FRAME);
`endif

  if (IPG_BYTES < 1 || IPG_BYTES > 255 ||
      PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15 ||
      MIN_FRAME < 1 || MIN_FRAME > 2047) begin : g_bad_param
    $error("gmii_tx_scheduler: parameter out of range");
  end

  state_t              state;
  logic [PRE_W-1:0]    pre_cnt;
  logic [BYTE_W-1:0]   byte_cnt;
  logic [BYTE_W-1:0]   byte_nx;
  logic [IPG_W-1:0]    ipg_cnt;
  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                advance;
  logic                g_valid;
  logic                g_last;
  logic                g_err;
  logic [7:0]          g_data;

  assign src0.ready = (state == ST_DATA) && grant[0];
  assign src1.ready = (state == ST_DATA) && grant[1];

  assign req     = {src1.valid, src0.valid};
  assign advance = (state == ST_IDLE) && !transmitting && (req != 2'b00);

  assign g_valid = grant[1] ? src1.valid : src0.valid;
  assign g_last  = grant[1] ? src1.last  : src0.last;
  assign g_err   = grant[1] ? src1.err   : src0.err;
  assign g_data  = grant[1] ? src1.data  : src0.data;

  assign byte_nx = (byte_cnt == ByteMax) ? byte_cnt : byte_cnt + 1'b1;

  rr_arb2 u_arb (
    .clk     (GTX_CLK),
    .rst_n   (mr_main_reset),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  // Outputs are written on the edge leaving a state, so TXD lags state by one.
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state    <= ST_IDLE;
      pre_cnt  <= '0;
      byte_cnt <= '0;
      ipg_cnt  <= '0;
      TXD      <= '0;
      TX_EN    <= 1'b0;
      TX_ER    <= 1'b0;
      grant    <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          TXD   <= '0;
          TX_EN <= 1'b0;
          TX_ER <= 1'b0;
          if (advance) begin
            grant   <= gnt;
            busy    <= 1'b1;
            pre_cnt <= '0;
            state   <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          TXD   <= PREAMBLE_BYTE;
          TX_EN <= 1'b1;
          TX_ER <= 1'b0;
          if (pre_cnt == PreLast) state <= ST_SFD;
          else pre_cnt <= pre_cnt + 1'b1;
        end
        ST_SFD: begin
          TXD      <= SFD_BYTE;
          TX_EN    <= 1'b1;
          TX_ER    <= 1'b0;
          byte_cnt <= '0;
          state    <= ST_DATA;
        end
        ST_DATA: begin
          TX_EN <= 1'b1;
          if (g_valid) begin
            TXD      <= g_data;
            TX_ER    <= g_err;
            byte_cnt <= byte_nx;
            if (g_last) begin
`ifdef GMII_TX_MIN_PAD_EN
              if (byte_nx < MinLen) begin
                state <= ST_PAD;
              end else begin
                grant   <= '0;
                ipg_cnt <= IpgLoad;
                state   <= ST_IPG;
              end
`else
              grant   <= '0;
              ipg_cnt <= IpgLoad;
              state   <= ST_IPG;
`endif
            end
          end else begin
            // underrun: PCS turns this into /V/
            TXD   <= '0;
            TX_ER <= 1'b1;
          end
        end
`ifdef GMII_TX_MIN_PAD_EN
        ST_PAD: begin
          TXD      <= '0;
          TX_EN    <= 1'b1;
          TX_ER    <= 1'b0;
          byte_cnt <= byte_nx;
          if (byte_nx >= MinLen) begin
            grant   <= '0;
            ipg_cnt <= IpgLoad;
            state   <= ST_IPG;
          end
        end
`endif
        ST_IPG: begin
          TXD   <= '0;
          TX_EN <= 1'b0;
          TX_ER <= 1'b0;
          grant <= '0;
          if (ipg_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            ipg_cnt <= ipg_cnt - 1'b1;
          end
        end
        default: begin
          TXD   <= '0;
          TX_EN <= 1'b0;
          TX_ER <= 1'b0;
          grant <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// Directed bench for gmii_tx_scheduler (default parameters).
// Expected frame lengths follow GMII_TX_MIN_PAD_EN when it is defined.
module tb_gmii_tx_scheduler;

  logic       GTX_CLK;
  logic       mr_main_reset;
  logic       transmitting;
  logic [7:0] TXD;
  logic       TX_EN;
  logic       TX_ER;
  logic [1:0] grant;
  logic       busy;

  gmii_tx_scheduler_if s0 ();
  gmii_tx_scheduler_if s1 ();

  gmii_tx_scheduler dut (
    .GTX_CLK       (GTX_CLK),
    .mr_main_reset (mr_main_reset),
    .src0          (s0),
    .src1          (s1),
    .transmitting  (transmitting),
    .TXD           (TXD),
    .TX_EN         (TX_EN),
    .TX_ER         (TX_ER),
    .grant         (grant),
    .busy          (busy)
  );

  initial begin
    GTX_CLK = 1'b0;
    forever #5 GTX_CLK = ~GTX_CLK;
  end

  int n_chk = 0;
  int n_err = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  bit         f0, f1;
  int         pop0, stall_at0, stall_left0;
  logic [9:0] tr[$];
  logic [1:0] gtr[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ent(logic e, logic l, logic [7:0] d);
    return {e, l, d};
  endfunction

  function automatic int trv(int i);
    if (i >= 0 && i < tr.size()) return int'(tr[i]);
    return 0;
  endfunction

  function automatic int gv(int i);
    if (i >= 0 && i < gtr.size()) return int'(gtr[i]);
    return 0;
  endfunction

  function automatic int frame_start(int k);
    int c = 0;
    for (int i = 0; i < tr.size(); i++) begin
      if (trv(i)[9] && !trv(i - 1)[9]) begin
        if (c == k) return i;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int run_len(int s);
    int n = 0;
    while (s >= 0 && trv(s + n)[9]) n++;
    return n;
  endfunction

  function automatic int low_run(int from, int lim);
    int n = 0;
    while (n < lim && (from + n) < tr.size() && !trv(from + n)[9]) n++;
    return n;
  endfunction

  function automatic int exp_len(int n);
`ifdef GMII_TX_MIN_PAD_EN
    return 8 + ((n < 60) ? 60 : n);
`else
    return 8 + n;
`endif
  endfunction

  task automatic drive();
    bit hold;
    hold = (stall_left0 > 0) && (pop0 == stall_at0) && (q0.size() != 0);
    if (hold) stall_left0--;
    if (q0.size() != 0 && !hold) begin
      s0.valid = 1'b1;
      {s0.err, s0.last, s0.data} = q0[0];
    end else begin
      s0.valid = 1'b0;
      {s0.err, s0.last, s0.data} = 10'h0;
    end
    if (q1.size() != 0) begin
      s1.valid = 1'b1;
      {s1.err, s1.last, s1.data} = q1[0];
    end else begin
      s1.valid = 1'b0;
      {s1.err, s1.last, s1.data} = 10'h0;
    end
  endtask

  task automatic step();
    @(negedge GTX_CLK);
    tr.push_back({TX_EN, TX_ER, TXD});
    gtr.push_back(grant);
    if (f0) begin
      void'(q0.pop_front());
      pop0++;
    end
    if (f1) void'(q1.pop_front());
    drive();
    f0 = s0.valid && s0.ready;
    f1 = s1.valid && s1.ready;
  endtask

  task automatic do_reset();
    mr_main_reset = 1'b0;
    q0.delete();
    q1.delete();
    f0 = 0;
    f1 = 0;
    pop0 = 0;
    stall_at0 = -1;
    stall_left0 = 0;
    transmitting = 1'b0;
    repeat (2) step();
    mr_main_reset = 1'b1;
    tr.delete();
    gtr.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_budget", (n < budget) ? 1 : 0, 1);
    repeat (20) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, len, prev_end, n, cnt, base, drop_idx;
    bit seen;
    logic [7:0] e;

    mr_main_reset = 1'b1;
    transmitting  = 1'b0;
    {s0.valid, s0.err, s0.last, s0.data} = 11'h0;
    {s1.valid, s1.err, s1.last, s1.data} = 11'h0;
    #2 mr_main_reset = 1'b0;
    #1;
    check("rst_txd",   TXD,      0);
    check("rst_txen",  TX_EN,    0);
    check("rst_txer",  TX_ER,    0);
    check("rst_grant", grant,    0);
    check("rst_busy",  busy,     0);
    check("rst_ready", {s1.ready, s0.ready}, 0);

    // single 3-byte frame
    do_reset();
    q0.push_back(ent(0, 0, 8'hA1));
    q0.push_back(ent(0, 0, 8'hA2));
    q0.push_back(ent(0, 1, 8'hA3));
    drain(300);
    s = frame_start(0);
    for (int i = 0; i < 11; i++) begin
      e = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'hA1 + 8'(i - 8);
      check("t1_byte", trv(s + i), {22'h0, 2'b10, e});
    end
    len = run_len(s);
    check("t1_len", len, exp_len(3));
    check("t1_gap", low_run(s + len, 12), 12);
    check("t1_grant", gv(s), 1);

    // both sources, three frames each
    do_reset();
    for (int f = 0; f < 3; f++) begin
      q0.push_back(ent(0, 0, 8'h10 + 8'(2 * f)));
      q0.push_back(ent(0, 1, 8'h11 + 8'(2 * f)));
      q1.push_back(ent(0, 0, 8'hB0 + 8'(2 * f)));
      q1.push_back(ent(0, 1, 8'hB1 + 8'(2 * f)));
    end
    drain(2000);
    prev_end = -1;
    for (int k = 0; k < 6; k++) begin
      s = frame_start(k);
      e = ((k % 2) == 0) ? 8'h10 : 8'hB0;
      e = e + 8'(2 * (k / 2));
      check("t2_grant", gv(s), ((k % 2) == 0) ? 1 : 2);
      check("t2_b0", trv(s + 8), {22'h0, 2'b10, e});
      check("t2_b1", trv(s + 9), {22'h0, 2'b10, e + 8'h1});
      len = run_len(s);
      check("t2_len", len, exp_len(2));
      if (k > 0) begin
        n = s - prev_end;
        check("t2_gap", (n >= 12 && n <= 14) ? 1 : 0, 1);
      end
      prev_end = s + len;
    end

    // underrun of two cycles, plus an errored byte
    do_reset();
    stall_at0 = 2;
    stall_left0 = 2;
    q0.push_back(ent(0, 0, 8'h31));
    q0.push_back(ent(0, 0, 8'h32));
    q0.push_back(ent(0, 0, 8'h33));
    q0.push_back(ent(0, 0, 8'h34));
    q0.push_back(ent(1, 1, 8'h35));
    drain(300);
    s = frame_start(0);
    check("t3_sfd",  trv(s + 7),  10'h2D5);
    check("t3_d0",   trv(s + 8),  10'h231);
    check("t3_d1",   trv(s + 9),  10'h232);
    check("t3_ur0",  trv(s + 10), 10'h300);
    check("t3_ur1",  trv(s + 11), 10'h300);
    check("t3_d2",   trv(s + 12), 10'h233);
    check("t3_d3",   trv(s + 13), 10'h234);
    check("t3_derr", trv(s + 14), 10'h335);
    check("t3_len",  run_len(s), exp_len(5) + 2);

    // PCS still transmitting holds off the next grant
    do_reset();
    q0.push_back(ent(0, 0, 8'h41));
    q0.push_back(ent(0, 1, 8'h42));
    seen = 0;
    n = 0;
    while (!(seen && !TX_EN) && n < 300) begin
      step();
      if (TX_EN) seen = 1;
      n++;
    end
    check("t4_frame_end", (n < 300) ? 1 : 0, 1);
    transmitting = 1'b1;
    q1.push_back(ent(0, 1, 8'h51));
    base = tr.size();
    repeat (20) step();
    cnt = 0;
    for (int i = base; i < base + 20; i++) begin
      if (trv(i)[9] || gv(i) != 0) cnt++;
    end
    check("t4_held", cnt, 0);
    check("t4_busy", busy, 0);
    check("t4_ready1", s1.ready, 0);
    drop_idx = tr.size();
    transmitting = 1'b0;
    drain(300);
    s = frame_start(1);
    check("t4_grant", gv(drop_idx), 2);
    check("t4_start", s - drop_idx, 1);
    check("t4_data", trv(s + 8), 10'h251);

    // padding of a 10-byte frame
    do_reset();
    for (int i = 0; i < 10; i++) q0.push_back(ent(0, (i == 9), 8'h60 + 8'(i)));
    drain(400);
    s = frame_start(0);
    len = run_len(s);
    check("t5_last", trv(s + 17), 10'h269);
    check("t5_len", len, exp_len(10));
    cnt = 0;
    for (int i = s + 18; i < s + len; i++) begin
      if (trv(i) == 10'h200) cnt++;
    end
    check("t5_pad", cnt, exp_len(10) - 18);

    // asynchronous reset in the middle of DATA
    do_reset();
    for (int i = 0; i < 20; i++) q0.push_back(ent(0, (i == 19), 8'h70 + 8'(i)));
    n = 0;
    while (!s0.ready && n < 50) begin
      step();
      n++;
    end
    check("t6_in_data", s0.ready, 1);
    repeat (3) step();
    check("t6_pre_en", TX_EN, 1);
    #2 mr_main_reset = 1'b0;
    #1;
    check("t6_txen",  TX_EN,    0);
    check("t6_grant", grant,    0);
    check("t6_busy",  busy,     0);
    check("t6_ready", s0.ready, 0);
    check("t6_txd",   TXD,      0);
    do_reset();
    q0.push_back(ent(0, 1, 8'hC0));
    q1.push_back(ent(0, 1, 8'hD0));
    drain(400);
    check("t6_first",  gv(frame_start(0)), 1);
    check("t6_second", gv(frame_start(1)), 2);
    check("t6_data",   trv(frame_start(0) + 8), 10'h2C0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
